// File: rtl/axi_7seg_scan_if.sv
// AXI4-Lite slave bundle for the multiplexed 7-segment scanner.
// The slave modport is the register block; the master modport is the bus side.
interface axi_7seg_scan_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_7seg_scan.sv
// AXI4-Lite multiplexed 7-segment controller: 1..16 digits, hex/raw per digit,
// DP mask, programmable scan rate, PWM brightness and a 1-clock guard blank per slot.
module axi_7seg_scan #(
    parameter int N_DIGITS           = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int SCAN_DIV_RST       = 50000,
    parameter bit SEG_ACTIVE_LOW     = 1,
    parameter bit AN_ACTIVE_LOW      = 1
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    axi_7seg_scan_if.slave      s_axi,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic [N_DIGITS-1:0] an_o
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int WA_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    logic                r_en;
    logic [7:0]          r_bright;
    logic [15:0]         r_scan_div;
    logic [N_DIGITS-1:0] r_dp_mask;
    logic [N_DIGITS-1:0] r_mode;
    logic [31:0]         r_digit [N_DIGITS];
    logic                r_wrap;

    logic [15:0]         r_slot;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_pwm;

    logic                r_awready;
    logic                r_arready;
    logic                r_bvalid;
    logic                r_rvalid;
    logic [31:0]         r_rdata;

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Register file read view, shared by the read port and the strobe merge on writes.
    function automatic logic [31:0] f_rd(input logic [WA_W-1:0] w);
        logic [31:0] v;
        v = '0;
        case (w)
            WA_W'(0): v = {16'h0, r_bright, 7'h0, r_en};
            WA_W'(1): v = {16'h0, r_scan_div};
            WA_W'(2): v = 32'(r_dp_mask);
            WA_W'(3): v = 32'(r_mode);
            WA_W'(4): v = {23'h0, r_wrap, 4'h0, 4'(r_idx)};
            default: begin
                for (int k = 0; k < N_DIGITS; k++)
                    if (w == WA_W'(16 + k)) v = r_digit[k];
            end
        endcase
        return v;
    endfunction

    wire [WA_W-1:0] w_waddr   = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    wire [WA_W-1:0] w_raddr   = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    wire            w_wr_fire = r_awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    wire            w_rd_fire = r_arready & s_axi.S_AXI_ARVALID;
    wire [31:0]     w_rdval   = f_rd(w_raddr);
    wire            w_unused  = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                                  s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    logic [31:0] w_wval;
    always_comb begin
        w_wval = f_rd(w_waddr);
        for (int b = 0; b < 4; b++)
            if (s_axi.S_AXI_WSTRB[b]) w_wval[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_awready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    // The !ready terms keep each ready a single-cycle pulse per accepted transfer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid & ~r_awready;
            r_arready <= s_axi.S_AXI_ARVALID & ~r_rvalid & ~r_arready;
            if (w_wr_fire)               r_bvalid <= 1'b1;
            else if (s_axi.S_AXI_BREADY) r_bvalid <= 1'b0;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdval;
            end else if (s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_en       <= 1'b0;
            r_bright   <= 8'hFF;
            r_scan_div <= 16'(SCAN_DIV_RST);
            r_dp_mask  <= '0;
            r_mode     <= '0;
            for (int k = 0; k < N_DIGITS; k++) r_digit[k] <= '0;
        end else if (w_wr_fire) begin
            case (w_waddr)
                WA_W'(0): begin
                    r_en     <= w_wval[0];
                    r_bright <= w_wval[15:8];
                end
                WA_W'(1): r_scan_div <= w_wval[15:0];
                WA_W'(2): r_dp_mask  <= w_wval[N_DIGITS-1:0];
                WA_W'(3): r_mode     <= w_wval[N_DIGITS-1:0];
                default: ;
            endcase
            for (int k = 0; k < N_DIGITS; k++)
                if (w_waddr == WA_W'(16 + k)) r_digit[k] <= w_wval;
        end
    end

    // >= rather than == so a divider shrunk below slot_cnt terminates on the next cycle.
    wire [15:0] w_div_m1 = (r_scan_div == 16'd0) ? 16'd0 : r_scan_div - 16'd1;
    wire        w_term   = r_slot >= w_div_m1;
    wire        w_last   = r_idx == IDX_W'(N_DIGITS - 1);
    wire        w_lit    = r_en && (r_slot != 16'd0) &&
                           ((r_pwm < r_bright) || (r_bright == 8'hFF));

    logic [6:0]          w_cur;
    logic                w_cur_raw;
    logic                w_cur_dp;
    logic [N_DIGITS-1:0] w_onehot;
    always_comb begin
        w_cur     = '0;
        w_cur_raw = 1'b0;
        w_cur_dp  = 1'b0;
        w_onehot  = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_cur       = r_digit[k][6:0];
                w_cur_raw   = r_mode[k];
                w_cur_dp    = r_dp_mask[k];
                w_onehot[k] = 1'b1;
            end
        end
    end
    wire [6:0] w_seg = w_cur_raw ? w_cur : f_hex(w_cur[3:0]);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_slot <= '0;
            r_idx  <= '0;
            r_pwm  <= '0;
            r_wrap <= 1'b0;
            an_o   <= AN_OFF;
            seg_o  <= SEG_OFF;
            dp_o   <= DP_OFF;
        end else begin
            r_pwm <= r_pwm + 8'd1;
            if (!r_en) begin
                r_slot <= '0;
                r_idx  <= '0;
            end else if (w_term) begin
                r_slot <= '0;
                r_idx  <= w_last ? '0 : r_idx + 1'b1;
            end else begin
                r_slot <= r_slot + 16'd1;
            end
            // A wrap in the same cycle as a STATUS read wins so the event is not lost.
            if (w_rd_fire && w_raddr == WA_W'(4)) r_wrap <= 1'b0;
            if (r_en && w_term && w_last)         r_wrap <= 1'b1;
            if (w_lit) begin
                an_o  <= AN_ACTIVE_LOW  ? ~w_onehot : w_onehot;
                seg_o <= SEG_ACTIVE_LOW ? ~w_seg    : w_seg;
                dp_o  <= SEG_ACTIVE_LOW ? ~w_cur_dp : w_cur_dp;
            end else begin
                an_o  <= AN_OFF;
                seg_o <= SEG_OFF;
                dp_o  <= DP_OFF;
            end
        end
    end
endmodule

// File: tb/tb_axi_7seg_scan.sv
// Randomised bench for axi_7seg_scan: register image model plus an arithmetic
// slot/digit model of the scanned pins (N_DIGITS=4, active-low pins).
module tb_axi_7seg_scan;
    localparam int N       = 4;
    localparam int DIV_RST = 50000;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [6:0]   seg_o;
    logic         dp_o;
    logic [N-1:0] an_o;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_reg [32];

    axi_7seg_scan_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)) ifc ();

    axi_7seg_scan #(.N_DIGITS(N), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7),
                    .SCAN_DIV_RST(DIV_RST), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(ifc.slave),
        .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] reg_mask(input int w);
        if (w == 0) return 32'h0000FF01;
        if (w == 1) return 32'h0000FFFF;
        if (w == 2 || w == 3) return (32'd1 << N) - 32'd1;
        if (w >= 16 && w < 16 + N) return 32'hFFFFFFFF;
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 32; w++) m_reg[w] = 32'h0;
        m_reg[0] = 32'h0000FF00;
        m_reg[1] = DIV_RST;
    endtask

    task automatic model_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int w;
        logic [31:0] bm;
        w = int'(addr[6:2]);
        bm = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        m_reg[w] = ((m_reg[w] & ~bm) | (data & bm)) & reg_mask(w);
    endtask

    // Expected pins at scan position pos (clocks since EN, counted in slot units).
    task automatic exp_pins(input int pos, output logic [N-1:0] an, output logic [6:0] seg, output logic dp);
        int div, slot, idx;
        logic [N-1:0] one;
        logic [31:0] d;
        div  = (m_reg[1][15:0] == 16'd0) ? 1 : int'(m_reg[1][15:0]);
        slot = pos % div;
        idx  = (pos / div) % N;
        one  = 1;
        an = '1; seg = 7'h7F; dp = 1'b1;
        if (slot != 0) begin
            d   = m_reg[16 + idx];
            an  = ~(one << idx);
            seg = ~(m_reg[3][idx] ? d[6:0] : HEX[d[3:0]]);
            dp  = ~m_reg[2][idx];
        end
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge ACLK);
        ifc.S_AXI_AWADDR = addr; ifc.S_AXI_AWVALID = 1'b1;
        ifc.S_AXI_WDATA = data;  ifc.S_AXI_WSTRB = strb; ifc.S_AXI_WVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ifc.S_AXI_AWREADY && n < 50);
        @(negedge ACLK);
        ifc.S_AXI_AWVALID = 1'b0; ifc.S_AXI_WVALID = 1'b0;
        n_checks++;
        if (n >= 50 || ifc.S_AXI_BVALID !== 1'b1 || ifc.S_AXI_BRESP !== 2'b00) begin
            n_errors++;
            $display("FAIL write_resp addr=%h bvalid=%b bresp=%b waited=%0d, required bvalid=1 bresp=00",
                     addr, ifc.S_AXI_BVALID, ifc.S_AXI_BRESP, n);
        end
        model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [6:0] addr, output logic [31:0] data);
        int n;
        @(negedge ACLK);
        ifc.S_AXI_ARADDR = addr; ifc.S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ifc.S_AXI_ARREADY && n < 50);
        @(negedge ACLK);
        ifc.S_AXI_ARVALID = 1'b0;
        data = ifc.S_AXI_RDATA;
        n_checks++;
        if (n >= 50 || ifc.S_AXI_RVALID !== 1'b1 || ifc.S_AXI_RRESP !== 2'b00) begin
            n_errors++;
            $display("FAIL read_resp addr=%h rvalid=%b rresp=%b waited=%0d, required rvalid=1 rresp=00",
                     addr, ifc.S_AXI_RVALID, ifc.S_AXI_RRESP, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [6:0] addrs [5];
        addrs = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h40};
        n_checks++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || ifc.S_AXI_AWREADY !== 1'b0 ||
            ifc.S_AXI_ARREADY !== 1'b0 || ifc.S_AXI_BVALID !== 1'b0 || ifc.S_AXI_RVALID !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pins an=%h seg=%h dp=%b, required an=f seg=7f dp=1 and no ready/valid",
                     an_o, seg_o, dp_o);
        end
        for (int i = 0; i < 5; i++) begin
            axi_read(addrs[i], rd);
            n_checks++;
            if (rd !== m_reg[addrs[i][6:2]]) begin
                n_errors++;
                $display("FAIL reset_reg addr=%h got=%h required=%h", addrs[i], rd, m_reg[addrs[i][6:2]]);
            end
        end
    endtask

    task automatic test_regs_random();
        logic [31:0] rd;
        logic [4:0] w;
        for (int i = 0; i < 24; i++) begin
            w = 5'($urandom_range(0, 31));
            if (w == 5'd4) w = 5'd5;
            axi_write({w, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 32; i++) begin
            if (i != 4) begin
                axi_read(7'(i * 4), rd);
                n_checks++;
                if (rd !== m_reg[i]) begin
                    n_errors++;
                    $display("FAIL reg_rand word=%0d got=%h required=%h", i, rd, m_reg[i]);
                end
            end
        end
        axi_write(7'h00, 32'h0000FF00, 4'hF);
    endtask

    task automatic test_wstrb_unmapped();
        logic [31:0] rd;
        axi_write(7'h40, 32'h0, 4'hF);
        axi_write(7'h40, 32'h12345678, 4'h2);
        axi_read(7'h40, rd);
        n_checks++;
        if (rd !== 32'h00005600) begin
            n_errors++;
            $display("FAIL wstrb got=%h required=00005600", rd);
        end
        axi_write(7'h3C, 32'hFFFFFFFF, 4'hF);
        axi_read(7'h3C, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_errors++;
            $display("FAIL unmapped got=%h required=00000000", rd);
        end
    endtask

    // variant 0: digits 1..4 hex; 1: MODE=2, DIGIT_1=0x55, DP=2; 2: fully random
    task automatic test_scan(input int variant);
        logic [N-1:0] an_e;
        logic [6:0] seg_e;
        logic dp_e;
        int n, bad;
        axi_write(7'h00, 32'h0000FF00, 4'hF);
        axi_write(7'h04, 32'd4, 4'hF);
        for (int k = 0; k < N; k++)
            axi_write(7'(8'h40 + 4 * k), (variant == 0) ? 32'(k + 1) : $urandom, 4'hF);
        if (variant == 1) begin
            axi_write(7'h44, 32'h55, 4'hF);
            axi_write(7'h0C, 32'h2, 4'hF);
            axi_write(7'h08, 32'h2, 4'hF);
        end else begin
            axi_write(7'h0C, (variant == 2) ? $urandom : 32'h0, 4'hF);
            axi_write(7'h08, (variant == 2) ? $urandom : 32'h0, 4'hF);
        end
        axi_write(7'h00, 32'h0000FF01, 4'hF);
        n = 0;
        while (an_o === 4'hF && n < 20) begin @(negedge ACLK); n++; end
        n_checks++;
        if (n >= 20) begin
            n_errors++;
            $display("FAIL scan_start variant=%0d no digit lit within 20 clocks", variant);
        end
        bad = 0;
        for (int pos = 1; pos <= 3 * N * 4; pos++) begin
            exp_pins(pos, an_e, seg_e, dp_e);
            n_checks++;
            if (an_o !== an_e || seg_o !== seg_e || dp_o !== dp_e) begin
                n_errors++;
                $display("FAIL scan v%0d pos=%0d an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                         variant, pos, an_o, seg_o, dp_o, an_e, seg_e, dp_e);
            end
            @(negedge ACLK);
        end
    endtask

    task automatic test_status_wrap();
        logic [31:0] rd;
        axi_write(7'h00, 32'h0000FF00, 4'hF);
        axi_read(7'h10, rd);
        n_checks++;
        if (rd !== 32'h00000100) begin
            n_errors++;
            $display("FAIL status_wrap got=%h required=00000100", rd);
        end
        axi_read(7'h10, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_errors++;
            $display("FAIL status_clear got=%h required=00000000", rd);
        end
    endtask

    task automatic test_bright();
        int lit, bad;
        axi_write(7'h04, 32'd1024, 4'hF);
        axi_write(7'h00, 32'h00004001, 4'hF);
        lit = 0; bad = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge ACLK);
            if (an_o !== 4'hF) begin
                lit++;
                if (!(an_o inside {4'hE, 4'hD, 4'hB, 4'h7})) bad++;
            end
        end
        n_checks++;
        if (lit < 1020 || lit > 1024) begin
            n_errors++;
            $display("FAIL bright_40 lit=%0d required 1020..1024 of 4096", lit);
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bright_onehot bad=%0d required=0", bad);
        end
        axi_write(7'h00, 32'h00000001, 4'hF);
        lit = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge ACLK);
            if (an_o !== 4'hF) lit++;
        end
        n_checks++;
        if (lit != 0) begin
            n_errors++;
            $display("FAIL bright_0 lit=%0d required=0", lit);
        end
    endtask

    task automatic test_aw_before_w();
        int n, early, pulses;
        logic [31:0] rd, d;
        d = $urandom;
        @(negedge ACLK);
        ifc.S_AXI_AWADDR = 7'h08; ifc.S_AXI_AWVALID = 1'b1;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            if (ifc.S_AXI_AWREADY !== 1'b0 || ifc.S_AXI_WREADY !== 1'b0 || ifc.S_AXI_BVALID !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_errors++;
            $display("FAIL lone_aw accepted_early=%0d required=0", early);
        end
        ifc.S_AXI_WDATA = d; ifc.S_AXI_WSTRB = 4'hF; ifc.S_AXI_WVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ifc.S_AXI_AWREADY && n < 50);
        @(negedge ACLK);
        ifc.S_AXI_AWVALID = 1'b0; ifc.S_AXI_WVALID = 1'b0;
        model_write(7'h08, d, 4'hF);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.S_AXI_BVALID === 1'b1) pulses++;
            @(negedge ACLK);
        end
        n_checks++;
        if (n >= 50 || pulses != 1) begin
            n_errors++;
            $display("FAIL aw_then_w bvalid_cycles=%0d waited=%0d required 1 response", pulses, n);
        end
        axi_read(7'h08, rd);
        n_checks++;
        if (rd !== m_reg[2]) begin
            n_errors++;
            $display("FAIL aw_then_w_data got=%h required=%h", rd, m_reg[2]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] rd;
        logic [6:0] addrs [5];
        addrs = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h40};
        axi_write(7'h04, 32'd4, 4'hF);
        axi_write(7'h00, 32'h0000FF01, 4'hF);
        @(negedge ACLK);
        ifc.S_AXI_BREADY = 1'b0;
        ifc.S_AXI_AWADDR = 7'h0C; ifc.S_AXI_AWVALID = 1'b1;
        ifc.S_AXI_WDATA = 32'hF; ifc.S_AXI_WSTRB = 4'hF; ifc.S_AXI_WVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ifc.S_AXI_AWREADY && n < 50);
        @(negedge ACLK);
        ifc.S_AXI_AWVALID = 1'b0; ifc.S_AXI_WVALID = 1'b0;
        while (an_o === 4'hF && n < 60) begin @(negedge ACLK); n++; end
        n_checks++;
        if (ifc.S_AXI_BVALID !== 1'b1 || an_o === 4'hF) begin
            n_errors++;
            $display("FAIL pre_reset bvalid=%b an=%b required bvalid held and a digit lit",
                     ifc.S_AXI_BVALID, an_o);
        end
        #2 ARESETN = 1'b0;
        #1;
        n_checks++;
        if (ifc.S_AXI_BVALID !== 1'b0 || an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset bvalid=%b an=%b seg=%h dp=%b, required 0 f 7f 1",
                     ifc.S_AXI_BVALID, an_o, seg_o, dp_o);
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        ifc.S_AXI_BREADY = 1'b1;
        model_reset();
        repeat (2) @(negedge ACLK);
        n_checks++;
        if (ifc.S_AXI_BVALID !== 1'b0 || an_o !== 4'hF) begin
            n_errors++;
            $display("FAIL post_reset bvalid=%b an=%b required 0 and f", ifc.S_AXI_BVALID, an_o);
        end
        for (int i = 0; i < 5; i++) begin
            axi_read(addrs[i], rd);
            n_checks++;
            if (rd !== m_reg[addrs[i][6:2]]) begin
                n_errors++;
                $display("FAIL post_reset_reg addr=%h got=%h required=%h", addrs[i], rd, m_reg[addrs[i][6:2]]);
            end
        end
    endtask

    initial begin
        ifc.S_AXI_AWADDR = '0; ifc.S_AXI_AWPROT = '0; ifc.S_AXI_AWVALID = 1'b0;
        ifc.S_AXI_WDATA = '0;  ifc.S_AXI_WSTRB = '0;  ifc.S_AXI_WVALID = 1'b0;
        ifc.S_AXI_BREADY = 1'b1;
        ifc.S_AXI_ARADDR = '0; ifc.S_AXI_ARPROT = '0; ifc.S_AXI_ARVALID = 1'b0;
        ifc.S_AXI_RREADY = 1'b1;
        model_reset();
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        test_reset();
        test_regs_random();
        test_wstrb_unmapped();
        test_scan(0);
        test_status_wrap();
        test_scan(1);
        test_scan(2);
        test_bright();
        test_aw_before_w();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
